// File: rtl/strobe_filter_pkg.sv
// Shared constants, types and the threshold helper for the multi-channel strobe filter.
package strobe_filter_pkg;

    localparam int unsigned LEN_W_DEF  = 13;
    localparam int unsigned OFFSET_DEF = 15;
    localparam int unsigned SAT_MAX    = (2 ** LEN_W_DEF) - 1;
    localparam int unsigned PERIOD_SAT = (2 ** LEN_W_DEF) - 16;

    // Per-channel output state: low (counting up / idle) or passing (holding / counting down)
    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_PASS = 1'b1
    } ch_state_e;

    // base*N + offset, with N=0 read as 1, clipped to sat
    function automatic logic [31:0] thr_calc(input logic [31:0] base,
                                             input logic [2:0]  n,
                                             input logic [31:0] offset,
                                             input logic [31:0] sat);
        logic [31:0] n_eff;
        logic [31:0] sum;
        n_eff = (n == 3'd0) ? 32'd1 : {29'd0, n};
        sum   = base * n_eff + offset;
        return (sum > sat) ? sat : sum;
    endfunction

endpackage

// File: rtl/strobe_filter_ch.sv
// One strobe channel: sync, polarity, fval mask, threshold latch, up/down
// width filter and saturating dropped-pulse counter.
import strobe_filter_pkg::*;

module strobe_filter_ch #(
    parameter int unsigned LEN_W  = LEN_W_DEF,
    parameter int unsigned DROP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_strobe,
    input  logic              i_pol,
    input  logic              i_mask_act,
    input  logic              i_enable,
    input  logic              i_filter_en,
    input  logic              i_drop_clr,
    input  logic [LEN_W-1:0]  iv_threshold,
    output logic [DROP_W-1:0] ov_drop_cnt,
    output logic              o_strobe
);

    logic [1:0]        stb_s;
    logic              strobe_int;
    logic              drop_ev;
    logic [LEN_W-1:0]  len_cnt;
    logic [LEN_W-1:0]  thr_c;
    logic [DROP_W-1:0] drop_cnt;
    ch_state_e         state;

    assign strobe_int  = (stb_s[1] ^ i_pol) & ~i_mask_act;
    // A pulse that ends before reaching the threshold leaves a non-zero count behind
    assign drop_ev     = i_enable & i_filter_en & (state == CH_IDLE) & ~strobe_int & (len_cnt != '0);
    assign o_strobe    = (state == CH_PASS);
    assign ov_drop_cnt = drop_cnt;

    // Two-flop synchroniser for the raw strobe
    always_ff @(posedge clk) begin
        if (reset) stb_s <= '0;
        else       stb_s <= {stb_s[0], i_strobe};
    end

    // Width filter: count up to thr_c before passing, count back down before releasing
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CH_IDLE;
            len_cnt <= '0;
            thr_c   <= '1;
        end else begin
            if (len_cnt == '0) thr_c <= iv_threshold;
            if (!i_enable || !i_filter_en) begin
                len_cnt <= '0;
                state   <= (i_enable && strobe_int) ? CH_PASS : CH_IDLE;
            end else begin
                case (state)
                    CH_IDLE: begin
                        if (strobe_int) begin
                            if (len_cnt == thr_c) state <= CH_PASS;
                            else                  len_cnt <= len_cnt + 1'b1;
                        end else begin
                            len_cnt <= '0;
                        end
                    end
                    CH_PASS: begin
                        if (!strobe_int) begin
                            if (len_cnt == '0) state <= CH_IDLE;
                            else               len_cnt <= len_cnt - 1'b1;
                        end
                    end
                    default: state <= CH_IDLE;
                endcase
            end
        end
    end

    // Saturating dropped-pulse counter; clear has priority over an increment
    always_ff @(posedge clk) begin
        if (reset || i_drop_clr)          drop_cnt <= '0;
        else if (drop_ev && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end

endmodule

// File: rtl/strobe_filter_mc.sv
// Multi-channel strobe filter top: frame/line sync, line-period measurement,
// global threshold and CH_NUM filter channels.
import strobe_filter_pkg::*;

module strobe_filter_mc #(
    parameter int unsigned CH_NUM = 2,
    parameter int unsigned LEN_W  = LEN_W_DEF,
    parameter int unsigned OFFSET = OFFSET_DEF,
    parameter int unsigned DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_acquisition_start,
    input  logic                     i_stream_enable,
    input  logic                     i_fval,
    input  logic                     i_lval,
    input  logic [CH_NUM-1:0]        iv_sensor_strobe,
    input  logic [CH_NUM-1:0]        iv_strobe_pol,
    input  logic                     i_filter_en,
    input  logic                     i_fval_mask,
    input  logic [2:0]               iv_min_lines,
    input  logic                     i_drop_clr,
    output logic [LEN_W-1:0]         ov_lperiod_reg,
    output logic [LEN_W-1:0]         ov_threshold,
    output logic [CH_NUM*DROP_W-1:0] ov_drop_cnt,
    output logic [CH_NUM-1:0]        ov_strobe_filter
);

    localparam int unsigned      SAT  = (2 ** LEN_W) - 1;
    localparam logic [LEN_W-1:0] PSAT = LEN_W'((2 ** LEN_W) - 16);

    logic [1:0]       fval_s;
    logic [3:0]       lval_s;
    logic             fval_q;
    logic             lval_rise;
    logic [1:0]       rise_cnt;
    logic [LEN_W-1:0] per_cnt;
    logic [LEN_W-1:0] lperiod_reg;
    logic [LEN_W-1:0] threshold;
    logic             lp_upd;
    logic             enable;

    assign fval_q         = fval_s[1];
    // lval runs two flops behind fval so a frame's first lval rise already sees fval=1
    assign lval_rise      = lval_s[2] & ~lval_s[3];
    assign ov_lperiod_reg = lperiod_reg;
    assign ov_threshold   = threshold;

    // fval/lval synchronisers and the registered enable
    always_ff @(posedge clk) begin
        if (reset) begin
            fval_s <= '0;
            lval_s <= '0;
            enable <= 1'b0;
        end else begin
            fval_s <= {fval_s[0], i_fval};
            lval_s <= {lval_s[2:0], i_lval};
            enable <= i_stream_enable & i_acquisition_start;
        end
    end

    // Line period: count from the first to the second lval rise of each frame.
    // The count also steps on the first rise itself so it equals the full period.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_cnt    <= '0;
            per_cnt     <= '0;
            lperiod_reg <= '1;
            lp_upd      <= 1'b0;
        end else begin
            lp_upd <= 1'b0;
            if (!fval_q) begin
                rise_cnt <= '0;
                per_cnt  <= '0;
            end else begin
                if (lval_rise && rise_cnt != 2'd2) rise_cnt <= rise_cnt + 1'b1;
                if ((rise_cnt == 2'd1 || (rise_cnt == 2'd0 && lval_rise)) && per_cnt != PSAT)
                    per_cnt <= per_cnt + 1'b1;
                if (lval_rise && rise_cnt == 2'd1) begin
                    lperiod_reg <= per_cnt + LEN_W'(OFFSET);
                    lp_upd      <= 1'b1;
                end
            end
        end
    end

    // Threshold follows one cycle after each new line period
    always_ff @(posedge clk) begin
        if (reset)       threshold <= '1;
        else if (lp_upd) threshold <= LEN_W'(thr_calc(32'(lperiod_reg) - 32'(OFFSET), iv_min_lines,
                                                      32'(OFFSET), 32'(SAT)));
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        strobe_filter_ch #(
            .LEN_W  (LEN_W),
            .DROP_W (DROP_W)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .i_strobe     (iv_sensor_strobe[g]),
            .i_pol        (iv_strobe_pol[g]),
            .i_mask_act   (i_fval_mask & fval_q),
            .i_enable     (enable),
            .i_filter_en  (i_filter_en),
            .i_drop_clr   (i_drop_clr),
            .iv_threshold (threshold),
            .ov_drop_cnt  (ov_drop_cnt[g*DROP_W +: DROP_W]),
            .o_strobe     (ov_strobe_filter[g])
        );
    end

endmodule

// File: tb/tb_strobe_filter_mc.sv
// Directed plus randomized bench for strobe_filter_mc with a pulse-level reference model.
module tb_strobe_filter_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_acquisition_start, i_stream_enable, i_fval, i_lval;
    logic [1:0]  iv_sensor_strobe, iv_strobe_pol;
    logic        i_filter_en, i_fval_mask, i_drop_clr;
    logic [2:0]  iv_min_lines;
    logic [12:0] ov_lperiod_reg, ov_threshold;
    logic [31:0] ov_drop_cnt;
    logic [1:0]  ov_strobe_filter;

    int total = 0;
    int bad   = 0;
    int drop_m [2];
    int t_m;
    logic [1:0] pol_v;

    always #5 clk = ~clk;

    strobe_filter_mc #(
        .CH_NUM (2),
        .LEN_W  (13),
        .OFFSET (15),
        .DROP_W (16)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .i_acquisition_start (i_acquisition_start),
        .i_stream_enable     (i_stream_enable),
        .i_fval              (i_fval),
        .i_lval              (i_lval),
        .iv_sensor_strobe    (iv_sensor_strobe),
        .iv_strobe_pol       (iv_strobe_pol),
        .i_filter_en         (i_filter_en),
        .i_fval_mask         (i_fval_mask),
        .iv_min_lines        (iv_min_lines),
        .i_drop_clr          (i_drop_clr),
        .ov_lperiod_reg      (ov_lperiod_reg),
        .ov_threshold        (ov_threshold),
        .ov_drop_cnt         (ov_drop_cnt),
        .ov_strobe_filter    (ov_strobe_filter)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Inputs are set before the call, captured on the edge, outputs read 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        iv_sensor_strobe = pol_v;
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic int t_model(input int p, input int n);
        int v;
        v = p * ((n == 0) ? 1 : n) + 15;
        return (v > 8191) ? 8191 : v;
    endfunction

    task automatic chk_drops(input string tag);
        chk({tag, "_drop0"}, {16'd0, ov_drop_cnt[15:0]},  32'(drop_m[0]));
        chk({tag, "_drop1"}, {16'd0, ov_drop_cnt[31:16]}, 32'(drop_m[1]));
    endtask

    // Frame with three lines of period p; model gives lperiod=p+15 and T=p*N+15
    task automatic frame(input int p, input int n);
        iv_min_lines = 3'(n);
        i_fval = 1'b1;
        for (int l = 0; l < 3; l++)
            for (int k = 0; k < p; k++) begin
                i_lval = (k < p / 2);
                step();
            end
        i_fval = 1'b0;
        i_lval = 1'b0;
        idle(10);
        t_m = t_model(p, n);
        chk("lperiod", 32'(ov_lperiod_reg), 32'(p + 15));
        chk("threshold", 32'(ov_threshold), 32'(t_m));
    endtask

    // Polarity is changed while bypassed so the sync latency cannot fake a pulse
    task automatic set_pol(input logic [1:0] p);
        i_filter_en      = 1'b0;
        pol_v            = p;
        iv_strobe_pol    = p;
        idle(4);
        i_filter_en      = 1'b1;
    endtask

    // Width-w pulses on each channel (0 = none); a pulse passes iff w > T, delayed T+2 steps from the pin
    task automatic pulse(input int w0, input int w1, input int t);
        int w [2];
        int len;
        logic e;
        w[0] = w0;
        w[1] = w1;
        len  = t + ((w0 > w1) ? w0 : w1) + 8;
        for (int k = 0; k < len; k++) begin
            for (int c = 0; c < 2; c++) iv_sensor_strobe[c] = (k < w[c]) ^ pol_v[c];
            step();
            for (int c = 0; c < 2; c++) begin
                e = (w[c] > t) && (k >= t + 2) && (k <= t + 1 + w[c]);
                chk($sformatf("out%0d_w%0d_k%0d", c, w[c], k), {31'd0, ov_strobe_filter[c]}, {31'd0, e});
            end
        end
        for (int c = 0; c < 2; c++)
            if (w[c] > 0 && w[c] <= t && drop_m[c] != 65535) drop_m[c]++;
        chk_drops("pulse");
    endtask

    // Bypass: output is the pin pattern (after polarity and fval mask) delayed two steps
    task automatic run_bypass(input int len, input bit directed, input bit mask);
        logic [1:0] act, e1, e2, eff;
        logic       fv;
        act = '0; fv = 1'b0; e1 = '0; e2 = '0;
        i_filter_en = 1'b0;
        i_fval_mask = mask;
        for (int k = 0; k < len; k++) begin
            if (directed) begin
                act = 2'b01;
                fv  = (k >= 20 && k < 40);
            end else begin
                for (int c = 0; c < 2; c++) if ($urandom_range(0, 3) == 0) act[c] = ~act[c];
                if ($urandom_range(0, 15) == 0) fv = ~fv;
            end
            iv_sensor_strobe = act ^ pol_v;
            i_fval = fv;
            step();
            eff = act & ~{2{mask & fv}};
            chk($sformatf("bypass_k%0d", k), {30'd0, ov_strobe_filter}, {30'd0, e2});
            e2 = e1;
            e1 = eff;
        end
        i_fval = 1'b0;
        idle(4);
        i_filter_en = 1'b1;
        i_fval_mask = 1'b0;
        chk_drops("bypass");
    endtask

    initial begin
        int p, n, w0, w1;
        logic [1:0] rp;
        reset = 1'b1;
        i_acquisition_start = 1'b1;
        i_stream_enable = 1'b1;
        i_fval = 1'b0;
        i_lval = 1'b0;
        pol_v = '0;
        iv_strobe_pol = '0;
        iv_sensor_strobe = '0;
        i_filter_en = 1'b1;
        i_fval_mask = 1'b0;
        iv_min_lines = 3'd1;
        i_drop_clr = 1'b0;
        drop_m[0] = 0;
        drop_m[1] = 0;
        t_m = 8191;
        idle(3);
        reset = 1'b0;
        idle(3);
        chk("rst_lperiod", 32'(ov_lperiod_reg), 32'd8191);
        chk("rst_threshold", 32'(ov_threshold), 32'd8191);
        chk("rst_out", {30'd0, ov_strobe_filter}, 32'd0);
        chk_drops("rst");

        // No frame yet: a long strobe is blocked and counted as a drop
        pulse(3000, 0, 8191);

        // N=1, period 100: T=115
        frame(100, 1);
        pulse(100, 0, t_m);
        pulse(200, 0, t_m);

        // N=3: T=315
        frame(100, 3);
        pulse(300, 0, t_m);
        pulse(400, 0, t_m);

        // Active-low channel 1
        frame(100, 1);
        set_pol(2'b10);
        pulse(0, 200, t_m);
        set_pol(2'b00);

        run_bypass(60, 1'b1, 1'b1);
        run_bypass(200, 1'b0, 1'($urandom_range(0, 1)));

        // Enable dropped while passing: output low on the step after enable registers low
        for (int k = 0; k < 250; k++) begin
            iv_sensor_strobe[0] = (k < 200);
            i_stream_enable = (k < 150);
            step();
            chk($sformatf("en_out_k%0d", k), {31'd0, ov_strobe_filter[0]},
                {31'd0, (k >= 117 && k <= 150)});
        end
        chk_drops("en_pass");
        // Enable dropped during the count-up: discarded, not a drop
        i_stream_enable = 1'b1;
        idle(5);
        for (int k = 0; k < 100; k++) begin
            iv_sensor_strobe[0] = (k < 80);
            i_stream_enable = (k < 40);
            step();
            chk("en_inflight_out", {31'd0, ov_strobe_filter[0]}, 32'd0);
        end
        chk_drops("en_inflight");
        i_stream_enable = 1'b1;
        idle(5);

        // Clear lands on the same edge as a drop increment (50-cycle pulse, step 52)
        for (int k = 0; k < 60; k++) begin
            iv_sensor_strobe[0] = (k < 50);
            i_drop_clr = (k == 52);
            step();
            if (k == 51) chk("clr_before", {16'd0, ov_drop_cnt[15:0]}, 32'(drop_m[0]));
            if (k >= 52) begin
                chk("clr_drop0", {16'd0, ov_drop_cnt[15:0]}, 32'd0);
                chk("clr_drop1", {16'd0, ov_drop_cnt[31:16]}, 32'd0);
            end
        end
        drop_m[0] = 0;
        drop_m[1] = 0;

        // Randomized frames, N, polarity and widths clustered on the threshold
        for (int it = 0; it < 10; it++) begin
            p  = $urandom_range(40, 120);
            n  = $urandom_range(0, 7);
            frame(p, n);
            rp = 2'($urandom_range(0, 3));
            set_pol(rp);
            w0 = t_m - 3 + $urandom_range(0, 6);
            w1 = $urandom_range(0, t_m + 60);
            pulse(w0, w1, t_m);
        end
        set_pol(2'b00);

        // Reset while passing drops the output on that edge and restores reset values
        frame(100, 1);
        for (int k = 0; k < 134; k++) begin
            iv_sensor_strobe[0] = (k < 130);
            reset = (k >= 130);
            step();
            if (k == 125) chk("pre_reset_out", {31'd0, ov_strobe_filter[0]}, 32'd1);
            if (k >= 130) chk("reset_out", {31'd0, ov_strobe_filter[0]}, 32'd0);
        end
        reset = 1'b0;
        idle(2);
        chk("reset_lperiod", 32'(ov_lperiod_reg), 32'd8191);
        chk("reset_threshold", 32'(ov_threshold), 32'd8191);
        drop_m[0] = 0;
        drop_m[1] = 0;
        chk_drops("reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/strobe_filter_mc.md
Name: strobe_filter_mc

Overview:
Parametrised multi-channel successor to the single-channel sensor strobe filter. It measures the sensor line period inside each frame, derives a programmable pulse-width threshold of N line periods plus a fixed offset, and suppresses strobe pulses at or below that threshold on each channel. Surviving pulses keep their width and are delayed by the threshold. It adds per-channel polarity, a bypass mode, an optional fval mask and saturating dropped-pulse counters. It sits between the sensor IO pins and the flash/trigger output logic.

Parameters:
CH_NUM, 2, number of independent strobe channels (1..8)
LEN_W, 13, width of line-period, threshold and pulse counters
OFFSET, 15, clocks added to the measured line period
DROP_W, 16, width of each dropped-pulse counter

Ports:
clk  in  1  system clock, 72 MHz
reset  in  1  synchronous, active-high
i_acquisition_start  in  1  1 = acquire
i_stream_enable  in  1  1 = stream on
i_fval  in  1  frame valid; asynchronous; edge-aligned with lval
i_lval  in  1  line valid; asynchronous
iv_sensor_strobe  in  CH_NUM  raw strobes; asynchronous
iv_strobe_pol  in  CH_NUM  1 = channel is active-low, inverted after sync
i_filter_en  in  1  0 = bypass: output follows the synced strobe
i_fval_mask  in  1  1 = force strobe_int to 0 while fval=1
iv_min_lines  in  3  threshold multiplier N; 0 is treated as 1
i_drop_clr  in  1  single-cycle clear of all drop counters
ov_lperiod_reg  out  LEN_W  latched line period plus OFFSET
ov_threshold  out  LEN_W  current global threshold T
ov_drop_cnt  out  CH_NUM*DROP_W  per-channel dropped-pulse counts; channel 0 in the LSBs
ov_strobe_filter  out  CH_NUM  filtered strobes

Behaviour:
- Synchronisers: fval uses 2 flops. lval uses 4 flops so an lval rise is seen only after fval=1. Each strobe uses 2 flops, then XOR with its polarity bit.
- strobe_int[c] = synced strobe, forced to 0 when i_fval_mask=1 and synced fval=1.
- Line measurement:
  - 2-bit rise counter; cleared while fval=0; saturates at 2.
  - Period counter runs while the rise count is 1 and saturates at 2^LEN_W-16.
  - On the second lval rise of a frame, lperiod_reg <= cnt + OFFSET.
- Threshold: registered one cycle after an lperiod_reg update. T = lperiod_reg*N + OFFSET*(1-N); equivalently (cnt)*N + OFFSET, saturating to all-ones.
- Per channel:
  - Latch T into thr_c while len_cnt==0, so a mid-pulse update has no effect.
  - Up/down counter, same rule as the single-channel filter.
    - out=0, strobe_int=1: count up, saturate at thr_c.
    - out=0, strobe_int=0: clear.
    - out=1, strobe_int=1: hold.
    - out=1, strobe_int=0: count down, saturate at 0.
  - out sets when strobe_int=1 and cnt==thr_c; clears when strobe_int=0 and cnt==0.
- Timing and width:
  - Output rises on the (T+1)th clk edge after strobe_int rises.
  - A strobe_int pulse of W cycles passes iff W > T; output width is exactly W.
  - A re-assertion during the down-count holds the count and merges into one output pulse.
- Drop counter: increments when strobe_int falls while out=0 and cnt>0. It saturates at all-ones. i_drop_clr wins over a simultaneous increment.
- enable = registered (i_stream_enable & i_acquisition_start). enable=0 forces out=0 on the next edge and clears len_cnt. In-flight pulses are discarded and not counted as drops.
- Bypass (i_filter_en=0): out = strobe_int & enable, registered with 1 cycle latency. Counters stay cleared.
- Reset values:
  - lperiod_reg and threshold: all-ones, so the first frame blocks every strobe.
  - Synchronisers, counters, ov_strobe_filter and ov_drop_cnt: 0.
  - Reset mid-pulse drops the output on the next edge.

Decomposition:
- Package strobe_filter_pkg: LEN_W default, OFFSET, SAT_MAX = 2^LEN_W-1, PERIOD_SAT = 2^LEN_W-16, and the helper function for the saturating multiply-add.
- Sub-module strobe_filter_ch: one channel's polarity, mask, threshold latch, up/down counter, output and drop counter.
- The top level holds the shared fval/lval measurement and the threshold, and instantiates CH_NUM channels.

Test Plan:
- After reset, a strobe of 3000 cycles with no frame yet: output stays 0, T=0x1FFF, drop_cnt=1 on falling.
- Frame with line period 100 clocks and N=1: lperiod_reg=115, T=115. A 100-cycle strobe is dropped (drop_cnt+1). A 200-cycle strobe gives a 200-cycle output rising 116 edges after strobe_int.
- N=3 with the same frame: T=315. A 300-cycle pulse is dropped; a 400-cycle pulse passes with width 400.
- Channel 1 with pol=1 and an active-low 200-cycle pulse: channel 1 output is a 200-cycle high pulse; channel 0 is unaffected.
- Bypass, or i_fval_mask=1 with a strobe held through fval=1: bypass output is the 1-cycle-delayed copy; masked output is low during fval.
- enable dropped mid-pulse, then i_drop_clr asserted together with a drop event: output is 0 on the next edge and drop_cnt reads 0.
